// File: rtl/branch_predict_gshare_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// The FSM state enum and the saturating counter helpers live here so the
// top level and the PHT storage agree on encodings and counter behaviour.
package bp_pkg;

  // Widest counter the helpers support; narrower counters are zero-extended.
  localparam int CTR_MAX_BITS = 4;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_t;

  // Saturating increment, sticking at 2^ctr_bits-1.
  function automatic logic [CTR_MAX_BITS-1:0] sat_inc(input logic [CTR_MAX_BITS-1:0] ctr,
                                                      input int ctr_bits);
    logic [CTR_MAX_BITS-1:0] max_val;
    max_val = CTR_MAX_BITS'((1 << ctr_bits) - 1);
    return (ctr >= max_val) ? max_val : ctr + CTR_MAX_BITS'(1);
  endfunction

  // Saturating decrement, sticking at zero.
  function automatic logic [CTR_MAX_BITS-1:0] sat_dec(input logic [CTR_MAX_BITS-1:0] ctr,
                                                      input int ctr_bits);
    logic [CTR_MAX_BITS-1:0] max_val;
    max_val = CTR_MAX_BITS'((1 << ctr_bits) - 1);
    if (ctr > max_val) return max_val;
    return (ctr == '0) ? '0 : ctr - CTR_MAX_BITS'(1);
  endfunction

endpackage

// File: rtl/branch_predict_gshare_if.sv
// Fetch/execute side bundle of the gshare predictor.
// master = pipeline side, slave = predictor side.
interface branch_predict_gshare_if #(
  parameter int PHT_INDEX_BITS = 10,
  parameter int GHR_BITS       = 10
);
  logic [31:0]               pcF;
  logic                      branchF;
  logic                      predict_takeF;
  logic [PHT_INDEX_BITS-1:0] PHT_indexF;
  logic [GHR_BITS-1:0]       ghrF;
  logic                      updateE;
  logic [PHT_INDEX_BITS-1:0] PHT_indexE;
  logic [GHR_BITS-1:0]       ghrE;
  logic                      actually_takenE;
  logic                      mispredictE;
  logic                      ready;
  logic [31:0]               branch_cnt;
  logic [31:0]               mispredict_cnt;

  modport master (
    output pcF, branchF, updateE, PHT_indexE, ghrE, actually_takenE, mispredictE,
    input  predict_takeF, PHT_indexF, ghrF, ready, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  pcF, branchF, updateE, PHT_indexE, ghrE, actually_takenE, mispredictE,
    output predict_takeF, PHT_indexF, ghrF, ready, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_gshare_pht_ram.sv
// Pattern history table storage: one asynchronous read port for fetch and
// one synchronous write port. The write port either loads a literal value
// (initialisation sweep) or applies a saturating step to the entry it names.
// A same-cycle read of the entry being written returns the old counter.
module bp_pht_ram
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 10,
  parameter int CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [CTR_BITS-1:0]   rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic                  wr_load,
  input  logic [CTR_BITS-1:0]   wr_value,
  input  logic                  wr_taken
);

  logic [CTR_BITS-1:0] mem_q [2**INDEX_BITS];
  logic [CTR_BITS-1:0] cur_ctr;
  logic [CTR_BITS-1:0] wr_data_d;

  assign rd_data = mem_q[rd_index];

  // Next value for the written entry: literal load or saturating step.
  always_comb begin
    cur_ctr   = mem_q[wr_index];
    wr_data_d = cur_ctr;
    if (wr_load) begin
      wr_data_d = wr_value;
    end else if (wr_taken) begin
      wr_data_d = CTR_BITS'(sat_inc(CTR_MAX_BITS'(cur_ctr), CTR_BITS));
    end else begin
      wr_data_d = CTR_BITS'(sat_dec(CTR_MAX_BITS'(cur_ctr), CTR_BITS));
    end
  end

  // Single synchronous write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_index] <= wr_data_d;
    end
  end

endmodule

// File: rtl/branch_predict_gshare.sv
// Gshare direction predictor: PC bits XOR speculative global history index
// a table of saturating counters. After reset the table is swept to weakly
// taken one entry per cycle before the predictor reports ready.
// Optional statistics counters are built when BPG_STATS_EN is defined;
// otherwise branch_cnt/mispredict_cnt are tied to zero.
module branch_predict_gshare
  import bp_pkg::*;
#(
  parameter int PHT_INDEX_BITS = 10,
  parameter int GHR_BITS       = 10,
  parameter int CTR_BITS       = 2,
  parameter int PC_LSB         = 2
) (
  input logic                   clk,
  input logic                   rst,
  branch_predict_gshare_if.slave bus
);

  localparam logic [CTR_BITS-1:0] WEAK_TAKEN = CTR_BITS'(1) << (CTR_BITS - 1);

  bp_state_t                 state_q, state_d;
  logic [PHT_INDEX_BITS-1:0] init_idx_q, init_idx_d;
  logic                      ready_q, ready_d;
  logic [GHR_BITS-1:0]       ghr_q, ghr_d;
  logic [GHR_BITS-1:0]       recover_ghr, shift_ghr;
  logic [PHT_INDEX_BITS-1:0] fetch_idx;
  logic [CTR_BITS-1:0]       rd_ctr;
  logic                      predict;
  logic                      wr_en, wr_load;
  logic [PHT_INDEX_BITS-1:0] wr_index;
  logic                      unused_bits;

  assign fetch_idx         = bus.pcF[PC_LSB +: PHT_INDEX_BITS] ^ PHT_INDEX_BITS'(ghr_q);
  assign predict           = ready_q & rd_ctr[CTR_BITS-1];
  assign bus.predict_takeF = predict;
  assign bus.PHT_indexF    = fetch_idx;
  assign bus.ghrF          = ghr_q;
  assign bus.ready         = ready_q;
  assign unused_bits       = ^{bus.pcF, rd_ctr};

  // History shift and misprediction repair values; a 1-bit history has no
  // older bits to keep.
  if (GHR_BITS > 1) begin : g_hist_wide
    assign recover_ghr = {bus.ghrE[GHR_BITS-2:0], bus.actually_takenE};
    assign shift_ghr   = {ghr_q[GHR_BITS-2:0], predict};
  end else begin : g_hist_narrow
    assign recover_ghr = bus.actually_takenE;
    assign shift_ghr   = predict;
  end

  // Init sweep walks every entry once, then hands over to normal operation.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    ready_d    = ready_q;
    if (state_q == BP_INIT) begin
      init_idx_d = init_idx_q + PHT_INDEX_BITS'(1);
      if (init_idx_q == '1) begin
        state_d = BP_RUN;
        ready_d = 1'b1;
      end
    end
  end

  // Repair on a resolved mispredict wins over the speculative fetch shift.
  always_comb begin
    ghr_d = ghr_q;
    if (state_q == BP_RUN) begin
      if (bus.updateE && bus.mispredictE) begin
        ghr_d = recover_ghr;
      end else if (bus.branchF) begin
        ghr_d = shift_ghr;
      end
    end
  end

  // Write port owner: init sweep while initialising, resolved branches after.
  always_comb begin
    wr_en    = 1'b0;
    wr_load  = 1'b0;
    wr_index = bus.PHT_indexE;
    if (state_q == BP_INIT) begin
      wr_en    = 1'b1;
      wr_load  = 1'b1;
      wr_index = init_idx_q;
    end else begin
      wr_en    = bus.updateE;
    end
  end

  // Control state and speculative history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BP_INIT;
      init_idx_q <= '0;
      ready_q    <= 1'b0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ready_q    <= ready_d;
      ghr_q      <= ghr_d;
    end
  end

  bp_pht_ram #(
    .INDEX_BITS(PHT_INDEX_BITS),
    .CTR_BITS  (CTR_BITS)
  ) u_pht (
    .clk     (clk),
    .rd_index(fetch_idx),
    .rd_data (rd_ctr),
    .wr_en   (wr_en),
    .wr_index(wr_index),
    .wr_load (wr_load),
    .wr_value(WEAK_TAKEN),
    .wr_taken(bus.actually_takenE)
  );

`ifdef BPG_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  // Resolved-branch and mispredict tallies, sticking at all-ones.
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (state_q == BP_RUN && bus.updateE) begin
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + 32'd1;
      if (bus.mispredictE && mispredict_cnt_q != '1) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;
`else
  assign bus.branch_cnt     = '0;
  assign bus.mispredict_cnt = '0;
`endif

endmodule

// File: doc/branch_predict_gshare.md
BRANCH_PREDICT_GSHARE -- requirements
Module: branch_predict_gshare

Interface
REQ-001 The block SHALL take parameter PHT_INDEX_BITS, default 10: log2 of the PHT entry count.
REQ-002 The block SHALL take parameter GHR_BITS, default 10: global history length, legal range 1..PHT_INDEX_BITS.
REQ-003 The block SHALL take parameter CTR_BITS, default 2: saturating counter width, legal range 1..4.
REQ-004 The block SHALL take parameter PC_LSB, default 2: lowest PC bit used for hashing.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port pcF, input, 32 bits: fetch PC.
REQ-008 The block SHALL have port branchF, input, 1 bit: the fetch slot holds a predecoded branch.
REQ-009 The block SHALL have port predict_takeF, output, 1 bit: predicted direction.
REQ-010 The block SHALL have port PHT_indexF, output, PHT_INDEX_BITS wide: index carried down the pipe.
REQ-011 The block SHALL have port ghrF, output, GHR_BITS wide: speculative history snapshot carried down the pipe.
REQ-012 The block SHALL have port updateE, input, 1 bit: a branch resolved this cycle.
REQ-013 The block SHALL have ports PHT_indexE (PHT_INDEX_BITS) and ghrE (GHR_BITS), inputs: the values carried from fetch.
REQ-014 The block SHALL have ports actually_takenE and mispredictE, inputs, 1 bit each: the resolved outcome.
REQ-015 The block SHALL have port ready, output, 1 bit: PHT initialisation complete.
REQ-016 The block SHALL have ports branch_cnt and mispredict_cnt, outputs, 32 bits each: statistics (see Configuration).

Function
REQ-017 PHT_indexF SHALL equal pcF[PC_LSB +: PHT_INDEX_BITS] XOR the zero-extended speculative GHR, combinationally.
REQ-018 predict_takeF SHALL equal the MSB of PHT[PHT_indexF] when ready=1, and 0 otherwise.
REQ-019 ghrF SHALL equal the current speculative GHR.
REQ-020 When branchF=1, ready=1 and no recovery occurs, the GHR SHALL shift left on the next edge with predict_takeF inserted at bit 0; otherwise the GHR SHALL hold.
REQ-021 When updateE=1 and mispredictE=1, the GHR SHALL load {ghrE[GHR_BITS-2:0], actually_takenE} on the next edge; recovery SHALL take priority over the REQ-020 shift; for GHR_BITS=1 it SHALL load actually_takenE.
REQ-022 When updateE=1 and ready=1, PHT[PHT_indexE] SHALL saturating-increment if actually_takenE=1 and saturating-decrement otherwise, with 1-cycle write latency; it SHALL NOT wrap at 0 or at 2^CTR_BITS-1.
REQ-023 A read and a write to the same index in the same cycle SHALL return the old counter, with no bypass.
REQ-024 The FSM SHALL have two states, INIT and RUN; INIT SHALL write 2^(CTR_BITS-1) (weakly taken) to one entry per cycle, index 0 upward.
REQ-025 INIT SHALL go to RUN after writing entry 2^PHT_INDEX_BITS-1, so ready rises exactly 2^PHT_INDEX_BITS cycles after rst deasserts.
REQ-026 During INIT, updateE and branchF SHALL be ignored.

Reset
REQ-027 rst SHALL asynchronously clear the GHR, the init index and both counters, set the FSM to INIT and set ready=0; PHT contents are undefined until INIT completes.
REQ-028 rst asserted mid-operation (including mid-INIT) SHALL restart INIT from index 0.

Configuration
REQ-029 With BPG_STATS_EN defined, branch_cnt SHALL increment on each updateE=1 in RUN, and mispredict_cnt SHALL increment when mispredictE is also 1; both SHALL saturate at 32'hFFFFFFFF.
REQ-030 Without BPG_STATS_EN, both ports SHALL remain present and tie to 0, and no counter logic SHALL be synthesised.

Structure
REQ-031 Package bp_pkg SHALL hold the bp_state_t enum (BP_INIT, BP_RUN) and the sat_inc/sat_dec functions parameterised on CTR_BITS.
REQ-032 The PHT SHALL be sub-module bp_pht_ram: 1 asynchronous read port, 1 synchronous write port, with the write port muxed between INIT and update.

Verification
REQ-033 The bench SHALL check init: with PHT_INDEX_BITS=4, rst deasserted -> ready=0 for 16 cycles, ready=1 on cycle 17, and every entry reads 2'b10.
REQ-034 The bench SHALL check saturation: 3 taken updates to index 5 -> counter 2'b11 and holds; then 4 not-taken updates -> 2'b00 and holds.
REQ-035 The bench SHALL check history: GHR=0, three branchF cycles predicting 1,0,1 -> ghrF=3'b101 in the low bits.
REQ-036 The bench SHALL check recovery priority: same cycle branchF=1 and updateE=mispredictE=1 with ghrE=10'h0F0 and taken=1 -> GHR=10'h1E1.
REQ-037 The bench SHALL check reset mid-INIT: rst pulsed at init index 7 -> INIT restarts at index 0 and ready stays low for the full 2^PHT_INDEX_BITS cycles.
REQ-038 The bench SHALL check stats with BPG_STATS_EN: 10 updates including 3 mispredicts -> branch_cnt=10 and mispredict_cnt=3; without the macro, both read 0.
